lsd_pingpong_buffer: RTL

//  Double-buffered (ping-pong) store for line segments produced by <simple_lsd>.

---
 rtl/lsd_pingpong_buffer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/lsd_pingpong_buffer.sv
// rtl/lsd_pingpong_buffer.sv - ping-pong segment store with length filter, overflow flag and PS release handshake
// One bank fills with the current frame while the PS reads the other; banks swap on commit if the PS has released.
module lsd_pingpong_buffer #(
    parameter int FRAME_HEIGHT = 8,
    parameter int FRAME_WIDTH  = 8,
    parameter int RAM_SIZE     = 2048,
    parameter int MIN_LENGTH   = 0,
    parameter int CNT_BITW     = 16,
    localparam int V_BITW      = $clog2(FRAME_HEIGHT),
    localparam int H_BITW      = $clog2(FRAME_WIDTH),
    localparam int ADDR_BITW   = $clog2(RAM_SIZE),
    localparam int WORD_SIZE   = 2 * (V_BITW + H_BITW)
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  in_flag,
    input  logic                  in_valid,
    input  logic [V_BITW-1:0]     in_start_v,
    input  logic [H_BITW-1:0]     in_start_h,
    input  logic [V_BITW-1:0]     in_end_v,
    input  logic [H_BITW-1:0]     in_end_h,
    input  logic                  in_rd_en,
    input  logic [ADDR_BITW-1:0]  in_rd_addr,
    input  logic                  in_release,
    output logic                  out_ready,
    output logic [ADDR_BITW:0]    out_line_num,
    output logic                  out_overflow,
    output logic                  out_rd_valid,
    output logic [WORD_SIZE-1:0]  out_data,
    output logic [V_BITW-1:0]     out_start_v,
    output logic [H_BITW-1:0]     out_start_h,
    output logic [V_BITW-1:0]     out_end_v,
    output logic [H_BITW-1:0]     out_end_h,
    output logic [CNT_BITW-1:0]   out_frame_cnt,
    output logic [CNT_BITW-1:0]   out_drop_cnt
);

    localparam int LEN_BITW = ((V_BITW > H_BITW) ? V_BITW : H_BITW) + 1;
    localparam logic [ADDR_BITW:0] RAM_FULL = (ADDR_BITW + 1)'(RAM_SIZE);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   commit;

    logic [WORD_SIZE-1:0]   mem [2][RAM_SIZE];
    logic                   fill_bank;
    logic [ADDR_BITW:0]     fill_cnt;
    logic                   sticky_ovf;

    logic [LEN_BITW-1:0]    len_v;
    logic [LEN_BITW-1:0]    len_h;
    logic [LEN_BITW-1:0]    seg_len;
    logic                   accept;
    logic                   wr_en;
    logic                   rd_hit;
    logic [WORD_SIZE-1:0]   wr_word;

    always_ff @(posedge clock) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Commit is the first cycle with in_flag low after a frame was in progress.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            IDLE: if (in_flag) state_next = FILL;
            FILL: if (!in_flag) begin
                state_next = IDLE;
                commit     = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        len_v   = (in_start_v >= in_end_v) ? LEN_BITW'(in_start_v - in_end_v)
                                           : LEN_BITW'(in_end_v - in_start_v);
        len_h   = (in_start_h >= in_end_h) ? LEN_BITW'(in_start_h - in_end_h)
                                           : LEN_BITW'(in_end_h - in_start_h);
        seg_len = len_v + len_h;
        accept  = in_flag && in_valid && ($unsigned(32'(seg_len)) >= $unsigned(32'(MIN_LENGTH)));
        wr_en   = accept && (fill_cnt != RAM_FULL) && !rst;
        wr_word = {in_start_v, in_start_h, in_end_v, in_end_h};
        rd_hit  = in_rd_en && out_ready && ({1'b0, in_rd_addr} < out_line_num);
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[fill_bank][fill_cnt[ADDR_BITW-1:0]] <= wr_word;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            fill_bank     <= 1'b0;
            fill_cnt      <= '0;
            sticky_ovf    <= 1'b0;
            out_ready     <= 1'b0;
            out_line_num  <= '0;
            out_overflow  <= 1'b0;
            out_frame_cnt <= '0;
            out_drop_cnt  <= '0;
        end else begin
            if (wr_en)       fill_cnt   <= fill_cnt + 1'b1;
            else if (accept) sticky_ovf <= 1'b1;

            if (in_release && out_ready) out_ready <= 1'b0;

            // Release is honoured before the swap decision, so both in one cycle republishes.
            if (commit) begin
                fill_cnt   <= '0;
                sticky_ovf <= 1'b0;
                if (fill_cnt != '0) begin
                    if (!out_ready || in_release) begin
                        fill_bank     <= ~fill_bank;
                        out_ready     <= 1'b1;
                        out_line_num  <= fill_cnt;
                        out_overflow  <= sticky_ovf;
                        out_frame_cnt <= out_frame_cnt + 1'b1;
                    end else begin
                        out_drop_cnt  <= out_drop_cnt + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            out_rd_valid <= 1'b0;
            out_data     <= '0;
        end else begin
            out_rd_valid <= in_rd_en;
            out_data     <= rd_hit ? mem[~fill_bank][in_rd_addr] : '0;
        end
    end

    assign {out_start_v, out_start_h, out_end_v, out_end_h} = out_data;

endmodule
